// File: rtl/taxi_pkg.sv
// Shared encodings for the taximeter: trip states, display pages and the
// increment widths the fare datapath sums on each metering strobe.
package taxi_pkg;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HIRED  = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_PAUSED = 3'd3;
   localparam logic [2:0] ST_SETTLE = 3'd4;

   localparam logic [1:0] PAGE_FARE = 2'd0;
   localparam logic [1:0] PAGE_DIST = 2'd1;
   localparam logic [1:0] PAGE_WAIT = 2'd2;
   localparam logic [1:0] PAGE_RATE = 2'd3;

   localparam int DIST_INC_W = 4;
   localparam int WAIT_INC_W = 2;
endpackage

// File: rtl/btn_debounce.sv
// Accepts an already-synchronised level once it has held a new value for
// DEBOUNCE_CYCLES consecutive cycles; emits the clean level and a rise pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_50MHz,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (din == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= din;
            rise  <= din;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/taxi_trip_ctrl.sv
// Trip sequencer: synchronises operator switches, runs the hire/run/pause/settle
// FSM and produces the once-per-second metering strobe with its increments.
module taxi_trip_ctrl
   import taxi_pkg::*;
#(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SETTLE_SEC      = 10
) (
   input  logic                  clk_50MHz,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  daynight,
   input  logic                  leap,
   input  logic [2:0]            speed,
   input  logic                  disp_ctrl,
   output logic                  clear,
   output logic                  tick_en,
   output logic [DIST_INC_W-1:0] dist_inc,
   output logic [WAIT_INC_W-1:0] wait_inc,
   output logic                  night_rate,
   output logic                  meter_on,
   output logic [1:0]            disp_sel,
   output logic [2:0]            state
);
   localparam int PRE_W = $clog2(TICK_DIV + 1);
   localparam int SET_W = $clog2(SETTLE_SEC + 1);

   function automatic logic [DIST_INC_W-1:0] dist_units(input logic [2:0] spd, input logic lp);
      return DIST_INC_W'({1'b0, spd} << lp);
   endfunction

   function automatic logic [WAIT_INC_W-1:0] wait_units(input logic [2:0] spd, input logic lp);
      return (spd == 3'd0) ? (WAIT_INC_W'(1) << lp) : '0;
   endfunction

   logic [7:0] sync1, sync2;
   logic       start_s, pause_s, dn_s, leap_s, disp_s;
   logic [2:0] speed_s;
   logic       start_prev, primed, armed, start_rise;
   logic       disp_level, disp_rise;
   logic [PRE_W-1:0] presc, presc_nxt;
   logic [SET_W-1:0] settle_cnt;
   logic       sec_bnd;
   logic [2:0] nxt;

   assign {start_s, pause_s, dn_s, leap_s, disp_s, speed_s} = sync2;

   // A start held high through reset must not count as a rise: the detector only
   // arms after the synchronised level has been seen low following reset.
   assign start_rise = start_s & ~start_prev & armed;
   assign sec_bnd    = (presc == PRE_W'(TICK_DIV - 1));
   assign presc_nxt  = (state == ST_HIRED || sec_bnd) ? '0 : presc + 1'b1;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_disp_db (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .din       (disp_s),
      .level     (disp_level),
      .rise      (disp_rise)
   );

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:   if (start_rise) nxt = ST_HIRED;
         ST_HIRED:  nxt = ST_RUN;
         ST_RUN:    if (!start_s) nxt = ST_SETTLE; else if (pause_s) nxt = ST_PAUSED;
         ST_PAUSED: if (!start_s) nxt = ST_SETTLE; else if (!pause_s) nxt = ST_RUN;
         ST_SETTLE: begin
            if (start_rise) nxt = ST_HIRED;
            else if (sec_bnd && settle_cnt == SET_W'(SETTLE_SEC - 1)) nxt = ST_IDLE;
         end
         default:   nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         sync1      <= '0;
         sync2      <= '0;
         start_prev <= 1'b0;
         primed     <= 1'b0;
         armed      <= 1'b0;
      end else begin
         sync1      <= {start, pause, daynight, leap, disp_ctrl, speed};
         sync2      <= sync1;
         start_prev <= start_s;
         primed     <= 1'b1;
         if (primed && !sync1[7]) armed <= 1'b1;
      end
   end

   // Outputs are registered from the next-state view so each lines up with the
   // state it belongs to; tick_en marks the cycle in which the count is TICK_DIV-1.
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         presc      <= '0;
         settle_cnt <= '0;
         clear      <= 1'b0;
         tick_en    <= 1'b0;
         dist_inc   <= '0;
         wait_inc   <= '0;
         night_rate <= 1'b0;
         meter_on   <= 1'b0;
         disp_sel   <= PAGE_FARE;
      end else begin
         state    <= nxt;
         presc    <= presc_nxt;
         clear    <= (nxt == ST_HIRED);
         meter_on <= (nxt == ST_RUN) || (nxt == ST_PAUSED);
         tick_en  <= (nxt == ST_RUN) && (presc_nxt == PRE_W'(TICK_DIV - 1));
         if ((nxt == ST_RUN) && (presc_nxt == PRE_W'(TICK_DIV - 1))) begin
            dist_inc <= dist_units(speed_s, leap_s);
            wait_inc <= wait_units(speed_s, leap_s);
         end else begin
            dist_inc <= '0;
            wait_inc <= '0;
         end
         if (state != ST_SETTLE) settle_cnt <= '0;
         else if (sec_bnd)       settle_cnt <= settle_cnt + 1'b1;
         if (nxt == ST_HIRED) night_rate <= dn_s;
         if (nxt == ST_HIRED || state == ST_HIRED) disp_sel <= PAGE_FARE;
         else if (disp_rise && disp_level)         disp_sel <= disp_sel + 2'd1;
      end
   end
endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Directed bench for taxi_trip_ctrl; a monitor scores every metering strobe
// against a queue of hand-computed increments.
module tb_taxi_trip_ctrl;
   import taxi_pkg::*;

   localparam int TICK_DIV   = 10;
   localparam int DEB        = 4;
   localparam int SETTLE_SEC = 3;

   logic clk_50MHz = 1'b0;
   logic rst = 1'b1, start = 1'b0, pause = 1'b0, daynight = 1'b0, leap = 1'b0, disp_ctrl = 1'b0;
   logic [2:0] speed = 3'd0;
   logic clear, tick_en, night_rate, meter_on;
   logic [DIST_INC_W-1:0] dist_inc;
   logic [WAIT_INC_W-1:0] wait_inc;
   logic [1:0] disp_sel;
   logic [2:0] state;

   typedef struct {
      logic [3:0] d;
      logic [1:0] w;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   logic prev_tick = 1'b0;
   logic found;
   int   lat;
   int   total = 0;
   int   bad   = 0;

   taxi_trip_ctrl #(
      .TICK_DIV        (TICK_DIV),
      .DEBOUNCE_CYCLES (DEB),
      .SETTLE_SEC      (SETTLE_SEC)
   ) dut (
      .clk_50MHz  (clk_50MHz),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .daynight   (daynight),
      .leap       (leap),
      .speed      (speed),
      .disp_ctrl  (disp_ctrl),
      .clear      (clear),
      .tick_en    (tick_en),
      .dist_inc   (dist_inc),
      .wait_inc   (wait_inc),
      .night_rate (night_rate),
      .meter_on   (meter_on),
      .disp_sel   (disp_sel),
      .state      (state)
   );

   always #5 clk_50MHz = ~clk_50MHz;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_50MHz);
   endtask

   task automatic push(input int n, input logic [3:0] d, input logic [1:0] w);
      exp_t e;
      e.d = d;
      e.w = w;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      for (int c = 0; c < n * TICK_DIV + 20 && seen < n; c++) begin
         @(negedge clk_50MHz);
         if (tick_en) seen++;
      end
      check("tick_count", seen, n);
   endtask

   task automatic wait_clear(output logic f);
      f = 1'b0;
      for (int c = 0; c < 10 && !f; c++) begin
         @(negedge clk_50MHz);
         if (clear) f = 1'b1;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, state, ST_IDLE);
      check({tag, "_clear"}, clear, 0);
      check({tag, "_tick"}, tick_en, 0);
      check({tag, "_dist"}, dist_inc, 0);
      check({tag, "_wait"}, wait_inc, 0);
      check({tag, "_night"}, night_rate, 0);
      check({tag, "_meter"}, meter_on, 0);
      check({tag, "_disp"}, disp_sel, 0);
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk_50MHz) begin
      if (tick_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_tick", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("dist_inc", dist_inc, mon_e.d);
            check("wait_inc", wait_inc, mon_e.w);
         end
      end else if (prev_tick) begin
         check("dist_after_tick", dist_inc, 0);
         check("wait_after_tick", wait_inc, 0);
      end
      prev_tick = (tick_en === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(3);
      check_reset("reset");
      rst = 1'b0;
      cyc(3);

      // Hire with night tariff, speed 3
      daynight = 1'b1;
      speed = 3'd3;
      cyc(3);
      push(3, 4'd3, 2'd0);
      start = 1'b1;
      cyc(1); check("hire_lat1", state, ST_IDLE);
      cyc(1); check("hire_lat2", state, ST_IDLE);
      cyc(1);
      check("hire_state", state, ST_HIRED);
      check("hire_clear", clear, 1);
      check("hire_night", night_rate, 1);
      check("hire_disp", disp_sel, 0);
      cyc(1);
      check("run_state", state, ST_RUN);
      check("clear_one_cycle", clear, 0);
      check("run_meter_on", meter_on, 1);
      lat = 1;
      do begin
         cyc(1);
         lat++;
      end while (!tick_en && lat < 30);
      check("first_tick_lat", lat, 10);
      wait_ticks(2);

      speed = 3'd0; leap = 1'b1;
      push(2, 4'd0, 2'd2);
      wait_ticks(2);

      speed = 3'd7; daynight = 1'b0;
      push(2, 4'd14, 2'd0);
      wait_ticks(2);

      // Pause for 35 cycles: no strobes expected
      pause = 1'b1;
      cyc(5);
      check("paused_state", state, ST_PAUSED);
      check("paused_meter_on", meter_on, 1);
      cyc(30);
      pause = 1'b0;
      push(2, 4'd14, 2'd0);
      wait_ticks(2);
      check("night_hold", night_rate, 1);

      // Trip end right after a strobe: exit on the third second boundary
      start = 1'b0;
      cyc(3);
      check("settle_entry", state, ST_SETTLE);
      check("settle_meter_off", meter_on, 0);
      cyc(27);
      check("settle_hold", state, ST_SETTLE);
      cyc(1);
      check("settle_exit", state, ST_IDLE);
      check("queue_drained", exp_q.size(), 0);

      // Display: glitch then five clean presses
      disp_ctrl = 1'b1; cyc(3); disp_ctrl = 1'b0; cyc(10);
      check("disp_glitch", disp_sel, 0);
      for (int i = 0; i < 5; i++) begin
         disp_ctrl = 1'b1; cyc(8);
         disp_ctrl = 1'b0; cyc(8);
         check("disp_press", disp_sel, (i + 1) % 4);
      end

      // New hire resets the page; then end the trip quickly into SETTLE
      start = 1'b1;
      wait_clear(found);
      check("hire2_clear", found, 1);
      check("hire2_disp", disp_sel, 0);
      start = 1'b0;
      cyc(5);
      check("settle2_state", state, ST_SETTLE);

      // Start rise during SETTLE re-hires and re-latches the tariff
      start = 1'b1;
      wait_clear(found);
      check("settle_rehire_clear", found, 1);
      check("settle_rehire_state", state, ST_HIRED);
      check("night_relatch", night_rate, 0);
      cyc(1);
      check("rehire_run", state, ST_RUN);

      // Reset mid-RUN with start held high
      cyc(2);
      rst = 1'b1;
      #1;
      check_reset("midrun_rst");
      cyc(3);
      rst = 1'b0;
      cyc(20);
      check("no_rehire_held_start", state, ST_IDLE);
      check("no_rehire_clear", clear, 0);
      start = 1'b0;
      cyc(4);
      start = 1'b1;
      wait_clear(found);
      check("rehire_after_toggle", found, 1);
      check("rehire_after_toggle_state", state, ST_HIRED);
      check("queue_final", exp_q.size(), 0);

      rst = 1'b1;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/taxi_trip_ctrl.md
# taxi_trip_ctrl

Trip sequencer for the taximeter. It synchronises the operator switches, runs the hire/run/pause/settle state machine and generates the once-per-second metering strobe with distance and wait increments. It also latches the day/night tariff at hire and steps the display page. The fare accumulators and the BCD/7-segment path consume its outputs; it does no fare arithmetic itself.

## Interface
- `TICK_DIV`, 50_000_000, clk_50MHz cycles per metering second
- `DEBOUNCE_CYCLES`, 1_000_000, cycles disp_ctrl must be stable before acceptance (20 ms)
- `SETTLE_SEC`, 10, seconds the final fare is held after trip end
- `clk_50MHz`  in  1  system clock; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  raw trip switch, level; 1 = trip active
- `pause`  in  1  raw pause switch, level; 1 = metering frozen
- `daynight`  in  1  raw tariff switch; 1 = night
- `leap`  in  1  raw time-warp switch; 1 = double increments
- `speed`  in  3  speed switches; 0 = stationary
- `disp_ctrl`  in  1  raw display pushbutton
- `clear`  out  1  one-cycle pulse: zero all accumulators
- `tick_en`  out  1  one-cycle metering strobe
- `dist_inc`  out  4  distance units (0.25 km) to add on tick_en
- `wait_inc`  out  2  wait units (1.25 min) to add on tick_en
- `night_rate`  out  1  tariff latched at hire
- `meter_on`  out  1  1 in RUN or PAUSED
- `disp_sel`  out  2  page: 0 fare, 1 distance, 2 wait, 3 tariff
- `state`  out  3  current FSM state, for debug

## Operation
- All raw inputs pass through 2-FF synchronisers. Only the synchronised start is edge-detected.
- FSM states:
  - IDLE(0): on start rise → HIRED.
  - HIRED(1): lasts one cycle; asserts clear; latches night_rate ← daynight; resets prescaler and disp_sel to 0; → RUN.
  - RUN(2): pause=1 → PAUSED; start=0 → SETTLE.
  - PAUSED(3): pause=0 → RUN; start=0 → SETTLE. start=0 takes priority over pause.
  - SETTLE(4): counts SETTLE_SEC seconds, then → IDLE; a start rise → HIRED.
- Prescaler runs 0..TICK_DIV-1 and wraps. A second boundary occurs in the cycle where the count equals TICK_DIV-1. It runs free in every state except HIRED.
- tick_en = second boundary while in RUN only. Never asserted in IDLE, PAUSED or SETTLE.
- On tick_en:
  - dist_inc = speed << leap (max 14).
  - wait_inc = (speed==0) ? (1 << leap) : 0.
- Outside tick_en, dist_inc and wait_inc are 0.
- speed and leap are sampled synchronised in the tick cycle.
- night_rate is stable from HIRED until the next HIRED. Changes to daynight mid-trip are ignored.
- disp_ctrl:
  - The synchronised level must be stable for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  - An accepted rising edge advances disp_sel modulo 4 (3 wraps to 0). Valid in every state.
  - A press accepted in the same cycle as HIRED is discarded; the HIRED reset wins.
- SETTLE counter counts second boundaries, starting from 0 on entry. Exit to IDLE on the SETTLE_SEC-th boundary.

## Timing
- Reset values: state=IDLE, clear=0, tick_en=0, dist_inc=0, wait_inc=0, night_rate=0, meter_on=0, disp_sel=0. Prescaler, settle counter, synchronisers and debouncer are all 0.
- Reset asserted mid-trip forces IDLE immediately. After release, a start still held high is not a rise and does not hire; start must go 0→1.
- Start latency: raw start first sampled high at edge k → state=HIRED and clear=1 after edge k+2 → RUN after edge k+3.
- First tick_en occurs TICK_DIV cycles after the HIRED cycle.
- Pause/resume and trip end take effect 2 cycles after the raw change. A tick coinciding with the PAUSED or SETTLE transition cycle is suppressed.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package `taxi_pkg` holds:
  - state encodings IDLE..SETTLE;
  - page constants PAGE_FARE/DIST/WAIT/RATE;
  - unit widths DIST_INC_W=4 and WAIT_INC_W=2, shared with the fare datapath.
- Sub-module `btn_debounce` (parameter DEBOUNCE_CYCLES; output is a clean level plus a one-cycle rise pulse), instantiated once for disp_ctrl.

## Test plan
Bench parameters: TICK_DIV=10, DEBOUNCE_CYCLES=4, SETTLE_SEC=3.
- Hire: rst, then start 0→1 with daynight=1 → one clear pulse, night_rate=1, state 1 then 2. First tick_en 10 cycles after the clear cycle.
- Metering: speed=3, leap=0 → dist_inc=3, wait_inc=0 each tick. Then speed=0, leap=1 → dist_inc=0, wait_inc=2. Then speed=7, leap=1 → dist_inc=14.
- Pause: pause=1 for 35 cycles → no tick_en; pause=0 → ticks resume at the prescaler boundary. daynight toggled mid-trip → night_rate unchanged.
- Trip end: start=0 in RUN → SETTLE. After exactly 3 second boundaries → IDLE, with no tick_en throughout. A start rise during SETTLE → HIRED with a clear pulse.
- Display: 3-cycle glitch → no change. 5 clean presses → disp_sel 1,2,3,0,1. A new hire → disp_sel=0.
- Reset mid-RUN with start held high → IDLE, all outputs at reset values. No hire until start toggles 0→1.
